// File: rtl/mbr_slot_sched.sv
// Telemetry word-slot scheduler: tracks word/frame position from the MBR word tick,
// reserves leading sync slots and shares data slots among requesters round-robin.
module mbr_slot_sched #(
   parameter int NREQ             = 4,
   parameter int WORDS_PER_FRAME  = 32,
   parameter int SYNC_WORDS       = 2,
   parameter int FRAMES_PER_GROUP = 16,
   localparam int WW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1,
   localparam int FW = (FRAMES_PER_GROUP > 1) ? $clog2(FRAMES_PER_GROUP) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            word_tick,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic            slot_valid,
   output logic            slot_sync,
   output logic            idle_slot,
   output logic [WW-1:0]   word_idx,
   output logic [FW-1:0]   frame_idx,
   output logic            frame_start,
   output logic            group_start
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            slot_valid_q, slot_valid_d;
   logic            slot_sync_q, slot_sync_d;
   logic            idle_slot_q, idle_slot_d;
   logic [WW-1:0]   word_idx_q, word_idx_d;
   logic [FW-1:0]   frame_idx_q, frame_idx_d;
   logic            frame_start_q, frame_start_d;
   logic            group_start_q, group_start_d;
   logic [PW-1:0]   rr_q, rr_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic            load_slot;
   logic [WW-1:0]   slot_word;
   logic            last_word;
   logic            last_frame;

   // Scan from the highest offset down so the lowest offset from rr_q wins.
   always_comb begin
      int j;
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(rr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req[j]) begin
            win_found = 1'b1;
            win_idx   = PW'(j);
         end
      end
   end

   assign last_word  = (word_idx_q == WW'(WORDS_PER_FRAME - 1));
   assign last_frame = (frame_idx_q == FW'(FRAMES_PER_GROUP - 1));

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      slot_valid_d  = slot_valid_q;
      slot_sync_d   = slot_sync_q;
      idle_slot_d   = idle_slot_q;
      word_idx_d    = word_idx_q;
      frame_idx_d   = frame_idx_q;
      frame_start_d = 1'b0;
      group_start_d = 1'b0;
      rr_d          = rr_q;
      load_slot     = 1'b0;
      slot_word     = '0;

      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_ARM;
         end
         S_ARM: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (word_tick) begin
               state_d       = S_RUN;
               slot_valid_d  = 1'b1;
               word_idx_d    = '0;
               frame_idx_d   = '0;
               frame_start_d = 1'b1;
               group_start_d = 1'b1;
               load_slot     = 1'b1;
               slot_word     = '0;
            end
         end
         S_RUN: begin
            if (word_tick) begin
               if (last_word && !en) begin
                  // Stop lands on the frame boundary; round-robin history is kept.
                  state_d      = S_IDLE;
                  grant_d      = '0;
                  slot_valid_d = 1'b0;
                  slot_sync_d  = 1'b0;
                  idle_slot_d  = 1'b0;
                  word_idx_d   = '0;
                  frame_idx_d  = '0;
               end else begin
                  load_slot = 1'b1;
                  if (last_word) begin
                     slot_word     = '0;
                     frame_idx_d   = last_frame ? '0 : frame_idx_q + 1'b1;
                     frame_start_d = 1'b1;
                     group_start_d = last_frame;
                  end else begin
                     slot_word = word_idx_q + 1'b1;
                  end
                  word_idx_d = slot_word;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_slot) begin
         if (int'(slot_word) < SYNC_WORDS) begin
            slot_sync_d = 1'b1;
            grant_d     = '0;
            idle_slot_d = 1'b0;
         end else begin
            slot_sync_d = 1'b0;
            if (win_found) begin
               grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
               idle_slot_d = 1'b0;
               rr_d        = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end else begin
               grant_d     = '0;
               idle_slot_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         slot_valid_q  <= 1'b0;
         slot_sync_q   <= 1'b0;
         idle_slot_q   <= 1'b0;
         word_idx_q    <= '0;
         frame_idx_q   <= '0;
         frame_start_q <= 1'b0;
         group_start_q <= 1'b0;
         rr_q          <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         slot_valid_q  <= slot_valid_d;
         slot_sync_q   <= slot_sync_d;
         idle_slot_q   <= idle_slot_d;
         word_idx_q    <= word_idx_d;
         frame_idx_q   <= frame_idx_d;
         frame_start_q <= frame_start_d;
         group_start_q <= group_start_d;
         rr_q          <= rr_d;
      end
   end

   assign grant       = grant_q;
   assign slot_valid  = slot_valid_q;
   assign slot_sync   = slot_sync_q;
   assign idle_slot   = idle_slot_q;
   assign word_idx    = word_idx_q;
   assign frame_idx   = frame_idx_q;
   assign frame_start = frame_start_q;
   assign group_start = group_start_q;

endmodule

// File: tb/tb_mbr_slot_sched.sv
// Randomized bench for mbr_slot_sched, checked against a tick-count model of the frame.
module tb_mbr_slot_sched;
   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int S    = 2;
   localparam int F    = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            word_tick;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] grant;
   logic            slot_valid, slot_sync, idle_slot, frame_start, group_start;
   logic [4:0]      word_idx;
   logic [3:0]      frame_idx;

   mbr_slot_sched #(.NREQ(NREQ), .WORDS_PER_FRAME(W), .SYNC_WORDS(S), .FRAMES_PER_GROUP(F)) dut (
      .clk(clk), .rst(rst), .en(en), .word_tick(word_tick), .req(req),
      .grant(grant), .slot_valid(slot_valid), .slot_sync(slot_sync), .idle_slot(idle_slot),
      .word_idx(word_idx), .frame_idx(frame_idx), .frame_start(frame_start),
      .group_start(group_start)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2;
   int mode;
   int n;
   int ptr;
   int m_grant;
   bit m_idle, m_fs, m_gs;
   int total = 0;
   int fails = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      bit run;
      run = (mode == M_RUN);
      cmp({tag, ".grant"}, 32'(grant), run ? m_grant : 0);
      cmp({tag, ".slot_valid"}, 32'(slot_valid), 32'(run));
      cmp({tag, ".slot_sync"}, 32'(slot_sync), 32'(run && ((n % W) < S)));
      cmp({tag, ".idle_slot"}, 32'(idle_slot), 32'(run && m_idle));
      cmp({tag, ".word_idx"}, 32'(word_idx), run ? (n % W) : 0);
      cmp({tag, ".frame_idx"}, 32'(frame_idx), run ? ((n / W) % F) : 0);
      cmp({tag, ".frame_start"}, 32'(frame_start), 32'(m_fs));
      cmp({tag, ".group_start"}, 32'(group_start), 32'(m_gs));
   endtask

   function automatic void model_slot(input logic [NREQ-1:0] r);
      m_grant = 0;
      m_idle  = 1'b0;
      if ((n % W) >= S) begin
         m_idle = 1'b1;
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (m_idle && r[i]) begin
               m_grant = 1 << i;
               ptr     = (i + 1) % NREQ;
               m_idle  = 1'b0;
            end
         end
      end
   endfunction

   function automatic void model_tick(input logic [NREQ-1:0] r, input bit en_v);
      m_fs = 1'b0;
      m_gs = 1'b0;
      if (mode == M_ARM && en_v) begin
         mode = M_RUN;
         n    = 0;
         m_fs = 1'b1;
         m_gs = 1'b1;
         model_slot(r);
      end else if (mode == M_RUN) begin
         if ((n % W) == W - 1 && !en_v) begin
            mode    = M_IDLE;
            m_grant = 0;
            m_idle  = 1'b0;
         end else begin
            n++;
            m_fs = ((n % W) == 0);
            m_gs = ((n % (W * F)) == 0);
            model_slot(r);
         end
      end
   endfunction

   task automatic do_tick(input logic [NREQ-1:0] r, input int gap, input bit churn);
      @(negedge clk);
      req       = r;
      word_tick = 1'b1;
      model_tick(r, en);
      @(negedge clk);
      word_tick = 1'b0;
      check_all("tick");
      if (churn) req = NREQ'($urandom);
      m_fs = 1'b0;
      m_gs = 1'b0;
      repeat (gap) @(negedge clk);
      if (gap > 0) check_all("hold");
   endtask

   task automatic set_en(input bit v);
      @(negedge clk);
      en = v;
      @(negedge clk);
      if (mode == M_IDLE && v) mode = M_ARM;
      else if (mode == M_ARM && !v) mode = M_IDLE;
   endtask

   task automatic run_to_word(input int target);
      int guard;
      guard = 0;
      while (!(mode == M_RUN && (n % W) == target) && guard < 2 * W) begin
         do_tick(NREQ'($urandom), $urandom_range(1, 3), 1'b1);
         guard++;
      end
      cmp("run_to_word.bound", 32'(guard < 2 * W), 32'd1);
   endtask

   initial begin
      int gs_cnt;
      int guard;
      rst = 1'b1; en = 1'b0; word_tick = 1'b0; req = '0;
      mode = M_IDLE; n = 0; ptr = 0; m_grant = 0; m_idle = 0; m_fs = 0; m_gs = 0;
      repeat (3) @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // Idle: ticks ignored while disabled
      for (int i = 0; i < 3; i++) do_tick(NREQ'($urandom), 3, 1'b0);

      // Arm and enter the frame; first slots are sync
      set_en(1'b1);
      for (int i = 0; i < 3; i++) do_tick(NREQ'($urandom), 2, 1'b0);

      // All requesting: rotation through every source
      for (int i = 0; i < 8; i++) do_tick(4'b1111, 2, 1'b0);

      // Empty slot, then a grant that survives its request dropping
      do_tick(4'b0000, 2, 1'b0);
      do_tick(4'b0100, 0, 1'b0);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      check_all("req_drop");

      // A full group of frames with random requests
      gs_cnt = 0;
      for (int i = 0; i < W * F; i++) begin
         do_tick(NREQ'($urandom), $urandom_range(1, 2), $urandom_range(0, 1) == 1);
         if (mode == M_RUN && (n % (W * F)) == 0) gs_cnt++;
      end
      cmp("group_start_count", 32'(gs_cnt), 32'd1);

      // Stop request mid-frame finishes the frame
      run_to_word(10);
      set_en(1'b0);
      guard = 0;
      while (mode != M_IDLE && guard < 40) begin
         do_tick(NREQ'($urandom), 1, 1'b0);
         guard++;
      end
      cmp("stop_bound", 32'(mode == M_IDLE), 32'd1);
      check_all("stopped");

      // Stop cancelled by re-enabling before the frame boundary
      set_en(1'b1);
      do_tick(NREQ'($urandom), 1, 1'b0);
      run_to_word(5);
      set_en(1'b0);
      run_to_word(20);
      set_en(1'b1);
      run_to_word(W - 1);
      run_to_word(3);
      cmp("cancel_still_running", 32'(slot_valid), 32'd1);

      // Asynchronous reset mid-frame
      run_to_word(20);
      @(negedge clk);
      #2 rst = 1'b1;
      en = 1'b0;
      mode = M_IDLE; ptr = 0; m_grant = 0; m_idle = 0; m_fs = 0; m_gs = 0;
      #1 check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      set_en(1'b1);
      do_tick(NREQ'($urandom), 2, 1'b0);
      for (int i = 0; i < 6; i++) do_tick(NREQ'($urandom), 1, 1'b1);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/mbr_slot_sched.md
Name: mbr_slot_sched

Overview:
Word-slot scheduler for the telemetry frame built on the MBR word strobe. It consumes the per-word tick produced by the bit-rate divider and tracks word and frame position. Each data word slot is shared among NREQ data sources by round-robin arbitration, and the first SYNC_WORDS slots of every frame are reserved for the sync-word generator. It sits between the divider and the word multiplexer/serializer.

Parameters:
NREQ, 4, number of data requesters (2..8)
WORDS_PER_FRAME, 32, word slots per frame (>= SYNC_WORDS+1)
SYNC_WORDS, 2, reserved sync slots at start of each frame
FRAMES_PER_GROUP, 16, frames per group (frame counter modulus)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  scheduler enable
word_tick  in  1  one-clk strobe at each word boundary (from divider)
req  in  NREQ  per-source "word pending" request, level
grant  out  NREQ  one-hot slot owner, held for whole slot
slot_valid  out  1  a slot is in progress (RUN state)
slot_sync  out  1  current slot is a reserved sync slot
idle_slot  out  1  data slot with no owner (mux inserts filler)
word_idx  out  clog2(WORDS_PER_FRAME)  current word index in frame
frame_idx  out  clog2(FRAMES_PER_GROUP)  current frame index in group
frame_start  out  1  one-clk pulse when word 0 begins
group_start  out  1  one-clk pulse when word 0 of frame 0 begins

Behaviour:
- Reset (async, any state): state=IDLE; grant=0; slot_valid, slot_sync, idle_slot, frame_start, group_start=0; word_idx=0; frame_idx=0; rr pointer=0.
- All outputs registered; any slot change appears 1 clk after the word_tick cycle.
- States: IDLE, ARM, RUN.
- IDLE: all outputs at reset values; word_tick ignored; en=1 -> ARM.
- ARM: wait for word_tick. If en drops before it, return to IDLE. On word_tick with en=1 -> RUN, starting word_idx=0, frame_idx=0, frame_start=1, group_start=1.
- RUN, on word_tick: word_idx increments, wrapping WORDS_PER_FRAME-1 -> 0.
  - On wrap, frame_idx increments, wrapping FRAMES_PER_GROUP-1 -> 0.
  - frame_start pulses on every entry to word 0; group_start pulses only on word 0 of frame 0.
  - Between ticks all outputs hold; pulses last exactly 1 clk.
- Sync slots, word_idx < SYNC_WORDS: slot_sync=1, grant=0, idle_slot=0.
- Data slots:
  - req is sampled in the word_tick cycle.
  - Winner is the first asserted req scanning from rr pointer upward, modulo NREQ.
  - grant = one-hot winner; rr pointer = winner+1 mod NREQ. Pointer is unchanged when there is no winner.
  - No req asserted: grant=0, idle_slot=1.
- grant is not revoked if req drops mid-slot. req rising mid-slot waits for the next data slot.
- en=0 in RUN: the current frame completes. At the word_tick that would start word 0, go to IDLE instead; outputs return to reset values 1 clk later. en reasserted before that tick cancels the stop.
- word_tick asserted for consecutive clks: each cycle counts as a tick. Upstream guarantees spacing >= 2 clk.
- rst mid-frame: immediate return to IDLE; a new frame alignment occurs via ARM.

Test Plan:
1. rst=1 then 0, en=0, word_tick every 40 clk -> all outputs 0, word_idx=0, state stays IDLE.
2. en=1, first tick -> next clk: word_idx=0, frame_start=1, group_start=1, slot_sync=1, grant=0. Second tick -> word_idx=1, slot_sync=1. Third tick -> word_idx=2, slot_sync=0.
3. req=4'b1111 held, count 8 data slots -> grant sequence 0001, 0010, 0100, 1000, 0001, ... Each grant stays constant between ticks.
4. req=0 on a data slot -> idle_slot=1, grant=0. req=4'b0100 asserted, then dropped mid-slot -> grant=0100 held until the next tick.
5. 32*16 ticks -> word_idx wraps 31 -> 0 with frame_idx incrementing. frame_idx wraps 15 -> 0 with group_start=1 exactly once.
6. en=0 at word 10 -> slots continue to word 31; after the next tick, IDLE with outputs 0. Separately, rst asserted at word 20 -> outputs 0 asynchronously; re-enable -> ARM -> word 0 at next tick.
